bhand_serializer: RTL and testbench

//  Wide-to-narrow serializer fed by a bhand buffered-handshake stage.
//  - Accepts IN_WIDTH-bit words with a slice count and a last flag.
//  - Emits them as OUT_WIDTH-bit slices on a valid/ready interface.
//  - Sits between the packet-word bhand stage and the narrow snooper/forwarder datapath.
//  - Optionally re-registers its output through a bhand instance.

---
 rtl/bhand_serializer_pkg.sv | 19 +
 rtl/bhand_serializer_bhand.sv | 31 +++
 rtl/bhand_serializer.sv | 144 ++++++++++++++
 tb/tb_bhand_serializer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bhand_serializer_pkg.sv
// Shared types and helpers for the wide-to-narrow serializer.
// Holds the FSM state encoding and a constant clog2.
package bhand_serializer_pkg;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/bhand_serializer_bhand.sv
// Buffered-handshake register stage.
// Full-rate: ready is free when empty or when the sink drains.
module bhand #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] idata,
   input  logic                  idata_vld,
   output logic                  idata_rdy,
   output logic [DATA_WIDTH-1:0] odata,
   output logic                  odata_vld,
   input  logic                  odata_rdy
);

   assign idata_rdy = !odata_vld || odata_rdy;

   // Capture a new beat whenever the output slot is free or draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         odata     <= '0;
         odata_vld <= 1'b0;
      end else if (idata_rdy) begin
         odata_vld <= idata_vld;
         if (idata_vld) begin
            odata <= idata;
         end
      end
   end

endmodule

// File: rtl/bhand_serializer.sv
// Wide-to-narrow serializer with valid/ready on both sides.
// Optional bhand output register adds one cycle of latency.
module bhand_serializer
   import bhand_serializer_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter int MSB_FIRST = 1,
   parameter int OUT_BUF   = 0,
   localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
   localparam int NUM_W    = clog2(RATIO + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  idata,
   input  logic [NUM_W-1:0]     inum,
   input  logic                 ilast,
   input  logic                 idata_vld,
   output logic                 idata_rdy,
   output logic [OUT_WIDTH-1:0] odata,
   output logic                 olast,
   output logic                 odata_vld,
   input  logic                 odata_rdy
);

   localparam logic [NUM_W-1:0] RATIO_N = NUM_W'(RATIO);
   localparam logic [NUM_W-1:0] ONE_N   = NUM_W'(1);

   ser_state_t            state;
   ser_state_t            state_nxt;
   logic [IN_WIDTH-1:0]   hold;
   logic [IN_WIDTH-1:0]   hold_adv;
   logic [NUM_W-1:0]      rem;
   logic [NUM_W-1:0]      eff_num;
   logic                  hlast;
   logic                  int_vld;
   logic                  int_rdy;
   logic                  int_last;
   logic [OUT_WIDTH-1:0]  slice;
   logic                  word_done;
   logic                  shift_in;
   logic                  shift_out;

   // Out-of-range slice counts fall back to a full word.
   assign eff_num = (inum == '0 || inum > RATIO_N) ? RATIO_N : inum;

   assign word_done = (rem == ONE_N);
   assign shift_in  = idata_vld && idata_rdy;
   assign shift_out = int_vld && int_rdy;
   assign int_last  = int_vld && hlast && word_done;

   // The current slice always sits at one fixed end of the hold register.
   generate
      if (MSB_FIRST != 0) begin : g_msb
         assign slice    = hold[IN_WIDTH-1 -: OUT_WIDTH];
         assign hold_adv = hold << OUT_WIDTH;
      end else begin : g_lsb
         assign slice    = hold[OUT_WIDTH-1:0];
         assign hold_adv = hold >> OUT_WIDTH;
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SER_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; a finishing word may hand
   // straight over to the next one without an idle bubble.
   always_comb begin
      state_nxt = state;
      int_vld   = 1'b0;
      idata_rdy = 1'b0;
      unique case (state)
         SER_IDLE: begin
            idata_rdy = 1'b1;
            if (idata_vld) begin
               state_nxt = SER_SHIFT;
            end
         end
         SER_SHIFT: begin
            int_vld   = 1'b1;
            idata_rdy = word_done && int_rdy;
            if (shift_out && word_done && !idata_vld) begin
               state_nxt = SER_IDLE;
            end
         end
      endcase
   end

   // Hold register and remaining-slice counter; rem only
   // decrements above one so it can never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold  <= '0;
         rem   <= '0;
         hlast <= 1'b0;
      end else if (shift_in) begin
         hold  <= idata;
         rem   <= eff_num;
         hlast <= ilast;
      end else if (shift_out) begin
         if (word_done) begin
            rem   <= '0;
            hlast <= 1'b0;
         end else begin
            hold <= hold_adv;
            rem  <= rem - ONE_N;
         end
      end
   end

   generate
      if (OUT_BUF != 0) begin : g_buf
         logic [OUT_WIDTH:0] ob_data;

         bhand #(
            .DATA_WIDTH(OUT_WIDTH + 1)
         ) u_bhand (
            .clk       (clk),
            .rst       (rst),
            .idata     ({int_last, slice}),
            .idata_vld (int_vld),
            .idata_rdy (int_rdy),
            .odata     (ob_data),
            .odata_vld (odata_vld),
            .odata_rdy (odata_rdy)
         );

         assign odata = ob_data[OUT_WIDTH-1:0];
         assign olast = ob_data[OUT_WIDTH];
      end else begin : g_direct
         assign odata     = slice;
         assign olast     = int_last;
         assign odata_vld = int_vld;
         assign int_rdy   = odata_rdy;
      end
   endgenerate

endmodule

// File: tb/tb_bhand_serializer.sv
// Bench for bhand_serializer: vector table, directed corner
// sequences and a random scoreboard run, with and without OUT_BUF.
module tb_bhand_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] idata = '0;
   logic [2:0]  inum = '0;
   logic        ilast = 1'b0;
   logic        vld = 1'b0;
   logic        odata_rdy = 1'b1;
   logic        sel = 1'b0;

   logic        vld0, vld1;
   logic        rdy0, ol0, ov0;
   logic        rdy1, ol1, ov1;
   logic [7:0]  od0, od1;
   logic        irdy, ol, ov;
   logic [7:0]  od;

   always #5 clk = ~clk;

   assign vld0 = vld && !sel;
   assign vld1 = vld && sel;
   assign irdy = sel ? rdy1 : rdy0;
   assign ov   = sel ? ov1 : ov0;
   assign ol   = sel ? ol1 : ol0;
   assign od   = sel ? od1 : od0;

   bhand_serializer #(
      .IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1), .OUT_BUF(0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .idata(idata), .inum(inum), .ilast(ilast),
      .idata_vld(vld0), .idata_rdy(rdy0), .odata(od0), .olast(ol0),
      .odata_vld(ov0), .odata_rdy(odata_rdy)
   );

   bhand_serializer #(
      .IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1), .OUT_BUF(1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .idata(idata), .inum(inum), .ilast(ilast),
      .idata_vld(vld1), .idata_rdy(rdy1), .odata(od1), .olast(ol1),
      .odata_vld(ov1), .odata_rdy(odata_rdy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] slice_of(input logic [31:0] w, input int k);
      logic [31:0] s;
      s = (w >> (24 - 8 * k)) & 32'hFF;
      return s[7:0];
   endfunction

   function automatic int eff(input logic [2:0] n);
      return (n == 0 || n > 4) ? 4 : int'(n);
   endfunction

   logic [8:0] sbq[$];
   logic       mon_en = 1'b0;
   logic       rnd_on = 1'b0;

   initial begin : monitor
      logic       pstall;
      logic [7:0] pod;
      logic       pol;
      logic [8:0] e;
      int         n;
      pstall = 1'b0;
      pod = '0;
      pol = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            sbq.delete();
            pstall = 1'b0;
         end else begin
            if (pstall) begin
               check("stall_vld", ov, 1);
               check("stall_data", od, pod);
               check("stall_last", ol, pol);
            end
            if (ov && odata_rdy) begin
               if (sbq.size() == 0) begin
                  check("sb_underflow", sbq.size(), 1);
               end else begin
                  e = sbq.pop_front();
                  check("sb_slice", od, e[7:0]);
                  check("sb_last", ol, e[8]);
               end
            end
            if (vld && irdy) begin
               n = eff(inum);
               for (int k = 0; k < n; k++) begin
                  sbq.push_back({ilast && (k == n - 1), slice_of(idata, k)});
               end
            end
            pstall = ov && !odata_rdy;
            pod = od;
            pol = ol;
         end
      end
   end

   typedef struct {
      logic [31:0] w;
      logic [2:0]  n;
      logic        l;
      int          cnt;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[7];

   task automatic run_vec(input vec_t v, input int lat);
      logic [31:0] e;
      e = v.exp;
      @(posedge clk); #1;
      idata = v.w; inum = v.n; ilast = v.l; vld = 1'b1;
      @(negedge clk);
      check("vec_rdy", irdy, 1);
      @(posedge clk); #1;
      vld = 1'b0;
      idata = $urandom;
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         check("vec_lat", ov, 0);
         @(posedge clk); #1;
      end
      for (int k = 0; k < v.cnt; k++) begin
         @(negedge clk);
         check("vec_vld", ov, 1);
         check("vec_data", od, e[31-8*k -: 8]);
         check("vec_last", ol, v.l && (k == v.cnt - 1));
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("vec_idle", ov, 0);
   endtask

   task automatic run_t2();
      logic [63:0] e;
      e = 64'h1122334455667788;
      @(posedge clk); #1;
      idata = 32'h11223344; inum = 3'd4; ilast = 1'b0; vld = 1'b1;
      @(posedge clk); #1;
      idata = 32'h55667788; ilast = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("t2_vld", ov, 1);
         check("t2_data", od, e[63-8*(c-1) -: 8]);
         check("t2_rdy", irdy, (c == 4) || (c == 8));
         check("t2_last", ol, c == 8);
         @(posedge clk); #1;
         if (c == 4) vld = 1'b0;
      end
      @(negedge clk);
      check("t2_idle", ov, 0);
   endtask

   task automatic run_t5();
      logic [31:0] e;
      e = 32'hCAFEF00D;
      @(posedge clk); #1;
      idata = e; inum = 3'd4; ilast = 1'b1; vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t5_data", od, e[31-8*k -: 8]);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5_vld", ov, 0);
      check("t5_rdy", irdy, 1);
      check("t5_data0", od, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t5_quiet", ov, 0);
      end
   endtask

   task automatic run_rand(input int nw);
      logic acc;
      int   budget;
      @(posedge clk); #1;
      mon_en = 1'b1;
      rnd_on = 1'b1;
      fork
         begin
            for (int i = 0; i < nw; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  vld = 1'b0;
                  idata = $urandom;
                  @(posedge clk); #1;
               end
               vld = 1'b1;
               idata = $urandom;
               inum = 3'($urandom_range(0, 7));
               ilast = 1'($urandom_range(0, 1));
               acc = 1'b0;
               budget = 0;
               while (!acc && budget < 64) begin
                  @(negedge clk);
                  acc = irdy;
                  @(posedge clk); #1;
                  budget++;
                  if (!acc) idata = $urandom;
               end
               if (!acc) check("rand_accept", acc, 1);
               vld = 1'b0;
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk); #1;
               odata_rdy = 1'($urandom_range(0, 1));
            end
         end
      join
      odata_rdy = 1'b1;
      budget = 0;
      while ((sbq.size() > 0 || ov) && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      @(negedge clk);
      check("rand_drain", sbq.size(), 0);
      check("rand_drain_vld", ov, 0);
      mon_en = 1'b0;
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vt[0] = '{32'hAABBCCDD, 3'd4, 1'b1, 4, 32'hAABBCCDD};
      vt[1] = '{32'hDEADBEEF, 3'd2, 1'b0, 2, 32'hDEAD0000};
      vt[2] = '{32'h01020304, 3'd0, 1'b1, 4, 32'h01020304};
      vt[3] = '{32'h12345678, 3'd1, 1'b1, 1, 32'h12000000};
      vt[4] = '{32'h87654321, 3'd5, 1'b0, 4, 32'h87654321};
      vt[5] = '{32'hCAFEBABE, 3'd3, 1'b1, 3, 32'hCAFEBA00};
      vt[6] = '{32'h0F1E2D3C, 3'd7, 1'b1, 4, 32'h0F1E2D3C};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdy0", rdy0, 1);
      check("rst_vld0", ov0, 0);
      check("rst_data0", od0, 0);
      check("rst_last0", ol0, 0);
      check("rst_rdy1", rdy1, 1);
      check("rst_vld1", ov1, 0);
      check("rst_data1", od1, 0);
      check("rst_last1", ol1, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      sel = 1'b0;
      for (int i = 0; i < 7; i++) run_vec(vt[i], 1);
      run_t2();
      run_t5();
      run_rand(1000);

      sel = 1'b1;
      for (int i = 0; i < 7; i++) run_vec(vt[i], 2);
      run_rand(1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
